// File: rtl/axis_pixel_tx.sv
// AXI4-Stream pixel transmitter: small FIFO fed by a free-running pixel stream, one output
// register, and a row/frame sequencer that generates TLAST, TUSER (SOF) and frame_done_o.
module axis_pixel_tx #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SIZE_W     = 9,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SIZE_W-1:0] IMG_SIZE_I,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_valid_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              frame_done_o,
  output logic              overflow_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(FIFO_DEPTH);

  typedef enum logic {StIdle, StStream} state_t;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]   r_count, w_count_nxt;
  logic              r_ready, r_overflow;

  state_t            r_state;
  logic [SIZE_W-1:0] r_nm1, r_col, r_row;
  logic [DATA_W-1:0] r_tdata;
  logic              r_tvalid, r_tlast, r_tuser, r_frame_done;

  logic              w_full, w_empty, w_push, w_pop, w_hs, w_last_beat, w_col_wrap;
  logic [SIZE_W-1:0] w_col_adv, w_row_adv, w_img_nm1;
  logic [DATA_W-1:0] w_head;

  assign w_full      = (r_count == Full);
  assign w_empty     = (r_count == '0);
  // A pop in the same cycle never makes room for a push into a full FIFO.
  assign w_push      = data_valid_i && !w_full;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_hs        = r_tvalid && m_axis_tready;
  assign w_col_wrap  = (r_col == r_nm1);
  assign w_last_beat = w_col_wrap && (r_row == r_nm1);
  assign w_col_adv   = w_col_wrap ? '0 : r_col + 1'b1;
  assign w_row_adv   = w_col_wrap ? r_row + 1'b1 : r_row;
  assign w_img_nm1   = (IMG_SIZE_I == '0) ? '0 : IMG_SIZE_I - 1'b1;

  // The last beat of a frame is not followed by a same-cycle load; IDLE latches the next N.
  always_comb begin
    w_pop = 1'b0;
    if (!w_empty) begin
      if (r_state == StIdle) begin
        w_pop = 1'b1;
      end else if (!r_tvalid || (w_hs && !w_last_beat)) begin
        w_pop = 1'b1;
      end
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CntW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ready    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != Full);
      if (data_valid_i && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_nm1        <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_tdata      <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_tuser      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_nm1    <= w_img_nm1;
            r_col    <= '0;
            r_row    <= '0;
            r_tdata  <= w_head;
            r_tvalid <= 1'b1;
            r_tuser  <= 1'b1;
            r_tlast  <= (w_img_nm1 == '0);
            r_state  <= StStream;
          end
        end
        StStream: begin
          if (w_hs) begin
            r_tuser <= 1'b0;
            if (w_last_beat) begin
              r_tvalid     <= 1'b0;
              r_tlast      <= 1'b0;
              r_frame_done <= 1'b1;
              r_state      <= StIdle;
            end else begin
              r_col <= w_col_adv;
              r_row <= w_row_adv;
              if (w_pop) begin
                r_tdata <= w_head;
                r_tlast <= (w_col_adv == r_nm1);
              end else begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
              end
            end
          end else if (!r_tvalid && w_pop) begin
            // Refill after a FIFO underrun; col/row already point at this beat.
            r_tdata  <= w_head;
            r_tvalid <= 1'b1;
            r_tlast  <= w_col_wrap;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ready_o       = r_ready;
  assign overflow_o    = r_overflow;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign frame_done_o  = r_frame_done;

endmodule

// File: tb/tb_axis_pixel_tx.sv
// Bench for axis_pixel_tx: a cycle-exact vector table for N=1 frames plus directed frame
// sequences checked against a beat model (value, col==N-1 -> tlast, first beat -> tuser).
module tb_axis_pixel_tx;

  logic       clk;
  logic       rst_n;
  logic [8:0] img_size;
  logic [7:0] data_i;
  logic       data_valid_i;
  logic       ready_o;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;
  logic       m_axis_tuser;
  logic       frame_done_o;
  logic       overflow_o;

  axis_pixel_tx #(
    .DATA_W(8),
    .SIZE_W(9),
    .FIFO_DEPTH(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .IMG_SIZE_I   (img_size),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .ready_o      (ready_o),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .frame_done_o (frame_done_o),
    .overflow_o   (overflow_o)
  );

  typedef struct packed {
    logic       rst_n;
    logic       vld;
    logic [7:0] din;
    logic       tvalid;
    logic [7:0] tdata;
    logic       tlast;
    logic       tuser;
    logic       done;
    logic       ready;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  int         done_cnt = 0;
  int         done_base = 0;
  int         tr_mode = 1;  // 0: tready low, 1: tready high, 2: toggle every cycle
  logic [9:0] beat_q[$];
  vec_t       tbl[10];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (tr_mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = ~m_axis_tready;
      endcase
    end
  end

  // Beat capture, SOF/TLAST hold check under backpressure and frame_done pulse count.
  initial begin
    logic       prev_stall;
    logic       prev_done;
    logic [9:0] prev_beat;
    prev_stall = 1'b0;
    prev_done  = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser},
                {1'b1, prev_beat});
        end
        if (m_axis_tvalid && m_axis_tready) begin
          beat_q.push_back({m_axis_tdata, m_axis_tlast, m_axis_tuser});
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_beat  = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
        if (frame_done_o && !prev_done) done_cnt++;
        prev_done = frame_done_o;
      end
    end
  end

  task automatic do_reset();
    rst_n        = 1'b0;
    data_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    beat_q.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    done_base = done_cnt;
  endtask

  task automatic push_pixels(input int n, input int first);
    for (int k = 0; k < n; k++) begin
      data_i       = 8'(first + k);
      data_valid_i = 1'b1;
      @(posedge clk);
      #1;
    end
    data_valid_i = 1'b0;
  endtask

  task automatic wait_beats(input string name, input int n, input int budget);
    int c;
    c = 0;
    while (beat_q.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    n_vec++;
    if (beat_q.size() < n) begin
      n_err++;
      $display("FAIL %s: got %0d beats, expected %0d", name, beat_q.size(), n);
    end
  endtask

  task automatic expect_beats(input string name, input int cnt, input int n, input int first,
                              input int start_idx);
    logic [9:0] b;
    logic [9:0] e;
    int         idx;
    for (int k = 0; k < cnt; k++) begin
      idx = start_idx + k;
      e   = {8'(first + k), (idx % n) == n - 1, idx == 0};
      if (beat_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL %s[%0d]: got no beat, expected 0x%0h", name, k, e);
      end else begin
        b = beat_q.pop_front();
        check($sformatf("%s[%0d]", name, k), 32'(b), 32'(e));
      end
    end
  endtask

  initial begin
    // N=1 frames: reset, then pixels A1..A3; one load bubble after every single-beat frame.
    tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 8'hA1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 8'hA2, 1'b1, 8'hA1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 8'hA3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hA2, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n        = 1'b1;
    img_size     = 9'd5;
    data_i       = 8'h00;
    data_valid_i = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_outputs", {ready_o, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser,
                            frame_done_o, overflow_o}, 32'd0);

    // 1: N=5, 25 pixels, tready=1
    do_reset();
    tr_mode  = 1;
    img_size = 9'd5;
    push_pixels(25, 1);
    wait_beats("t1_wait", 25, 200);
    expect_beats("t1", 25, 5, 1, 0);
    repeat (4) @(posedge clk);
    #1;
    check("t1_done", 32'(done_cnt - done_base), 32'd1);
    check("t1_ovf", 32'(overflow_o), 32'd0);

    // 2: N=5, tready toggling
    do_reset();
    tr_mode = 2;
    push_pixels(25, 1);
    wait_beats("t2_wait", 25, 300);
    expect_beats("t2", 25, 5, 1, 0);
    repeat (4) @(posedge clk);
    #1;
    check("t2_done", 32'(done_cnt - done_base), 32'd1);
    check("t2_ovf", 32'(overflow_o), 32'd0);

    // 3: N=8, tready held low, 20 pixels overflow the FIFO + output register
    do_reset();
    tr_mode  = 0;
    img_size = 9'd8;
    for (int k = 1; k <= 20; k++) begin
      data_i       = 8'(k);
      data_valid_i = 1'b1;
      @(posedge clk);
      #1;
      if (k == 16) check("t3_ready16", 32'(ready_o), 32'd1);
      if (k == 17) begin
        check("t3_ready17", 32'(ready_o), 32'd0);
        check("t3_ovf17", 32'(overflow_o), 32'd0);
      end
    end
    data_valid_i = 1'b0;
    check("t3_ovf20", 32'(overflow_o), 32'd1);
    tr_mode = 1;
    wait_beats("t3_wait", 17, 200);
    expect_beats("t3", 17, 8, 1, 0);
    repeat (10) @(posedge clk);
    #1;
    check("t3_extra_beats", 32'(beat_q.size()), 32'd0);
    check("t3_tvalid_end", 32'(m_axis_tvalid), 32'd0);
    check("t3_ovf_sticky", 32'(overflow_o), 32'd1);

    // 4: back-to-back frames, N=4 then N=3 (size changed mid-frame 1)
    do_reset();
    tr_mode  = 1;
    img_size = 9'd4;
    for (int k = 1; k <= 25; k++) begin
      data_i       = 8'(k);
      data_valid_i = 1'b1;
      @(posedge clk);
      #1;
      if (k == 5) img_size = 9'd3;
    end
    data_valid_i = 1'b0;
    wait_beats("t4_wait", 25, 300);
    expect_beats("t4_f1", 16, 4, 1, 0);
    expect_beats("t4_f2", 9, 3, 17, 0);
    repeat (4) @(posedge clk);
    #1;
    check("t4_done", 32'(done_cnt - done_base), 32'd2);

    // 5: reset mid-frame with pixels buffered
    do_reset();
    tr_mode  = 1;
    img_size = 9'd5;
    push_pixels(12, 1);
    wait_beats("t5_wait12", 12, 100);
    expect_beats("t5_pre", 12, 5, 1, 0);
    tr_mode = 0;
    push_pixels(6, 13);
    rst_n = 1'b0;
    #1;
    check("t5_reset_outputs", {ready_o, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
                               m_axis_tuser, frame_done_o, overflow_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    beat_q.delete();
    rst_n   = 1'b1;
    tr_mode = 1;
    @(posedge clk);
    #1;
    done_base = done_cnt;
    push_pixels(25, 1);
    wait_beats("t5_wait25", 25, 200);
    expect_beats("t5_post", 25, 5, 1, 0);
    repeat (4) @(posedge clk);
    #1;
    check("t5_done", 32'(done_cnt - done_base), 32'd1);

    // 6: N=1 cycle-exact table
    tr_mode  = 1;
    img_size = 9'd1;
    for (int i = 0; i < 10; i++) begin
      rst_n        = tbl[i].rst_n;
      data_valid_i = tbl[i].vld;
      data_i       = tbl[i].din;
      @(posedge clk);
      #1;
      if (tbl[i].tvalid) begin
        check($sformatf("t6_vec%0d", i),
              {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, frame_done_o,
               ready_o, overflow_o},
              {tbl[i].tvalid, tbl[i].tdata, tbl[i].tlast, tbl[i].tuser, tbl[i].done,
               tbl[i].ready, 1'b0});
      end else begin
        check($sformatf("t6_vec%0d", i),
              {m_axis_tvalid, frame_done_o, ready_o, overflow_o},
              {tbl[i].tvalid, tbl[i].done, tbl[i].ready, 1'b0});
      end
    end
    data_valid_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
